// File: rtl/sobel_window_ctrl.sv
// 3x3 window sequencer for the Sobel detector: two line buffers, row/column tracking,
// border gating of window validity and a 2-cycle sync/de delay aligned with the window.
module sobel_window_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_in,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       de,
    output logic [7:0] pixel_out1,
    output logic [7:0] pixel_out2,
    output logic [7:0] pixel_out3,
    output logic [7:0] pixel_out4,
    output logic [7:0] pixel_out5,
    output logic [7:0] pixel_out6,
    output logic [7:0] pixel_out7,
    output logic [7:0] pixel_out8,
    output logic [7:0] pixel_out9,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       de_out,
    output logic       win_valid,
    output logic       frame_err
);

    localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    localparam logic ST_WAIT_FRAME = 1'b0;
    localparam logic ST_ACTIVE     = 1'b1;

    logic             state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             err_q, err_d;
    logic [1:0]       hs_dly_q, hs_dly_d;
    logic [1:0]       vs_dly_q, vs_dly_d;
    logic [1:0]       de_dly_q, de_dly_d;
    logic [7:0]       pix_s1_q, pix_s1_d;
    logic             acc_s1_q, acc_s1_d;
    logic             vld_s1_q, vld_s1_d;
    logic             valid_q, valid_d;
    logic [7:0]       win_q [9];
    logic [7:0]       win_d [9];

    logic [7:0]       lb0 [H_ACTIVE];
    logic [7:0]       lb1 [H_ACTIVE];
    logic [7:0]       lb0_rd_q, lb1_rd_q;
    logic [AW-1:0]    addr;

    logic acc, vs_rise, de_rise, de_fall;

    // First delay stage doubles as the edge-detect history.
    assign vs_rise = vsync & ~vs_dly_q[0];
    assign de_rise = de & ~de_dly_q[0];
    assign de_fall = ~de & de_dly_q[0];
    assign addr    = col_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        err_d   = err_q;
        acc     = 1'b0;
        if (vs_rise) begin
            state_d = ST_ACTIVE;
            col_d   = '0;
            row_d   = '0;
            err_d   = de;
        end else if (state_q == ST_ACTIVE) begin
            if (de) begin
                if (row_q == V_MAX) begin
                    if (de_rise) err_d = 1'b1;
                end else if (col_q == H_MAX) begin
                    err_d = 1'b1;
                end else begin
                    acc   = 1'b1;
                    col_d = col_q + 1'b1;
                end
            end else if (de_fall) begin
                col_d = '0;
                if (row_q != V_MAX) row_d = row_q + 1'b1;
            end
        end
    end

    always_comb begin
        hs_dly_d = {hs_dly_q[0], hsync};
        vs_dly_d = {vs_dly_q[0], vsync};
        de_dly_d = {de_dly_q[0], de};
        pix_s1_d = pixel_in;
        acc_s1_d = acc;
        vld_s1_d = (col_q >= TWO) && (row_q >= TWO);
        valid_d  = acc_s1_q & vld_s1_q;
        win_d    = win_q;
        if (acc_s1_q) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb1_rd_q;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb0_rd_q;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pix_s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_WAIT_FRAME;
            col_q    <= '0;
            row_q    <= '0;
            err_q    <= 1'b0;
            hs_dly_q <= '0;
            vs_dly_q <= '0;
            de_dly_q <= '0;
            pix_s1_q <= '0;
            acc_s1_q <= 1'b0;
            vld_s1_q <= 1'b0;
            valid_q  <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            err_q    <= err_d;
            hs_dly_q <= hs_dly_d;
            vs_dly_q <= vs_dly_d;
            de_dly_q <= de_dly_d;
            pix_s1_q <= pix_s1_d;
            acc_s1_q <= acc_s1_d;
            vld_s1_q <= vld_s1_d;
            valid_q  <= valid_d;
            win_q    <= win_d;
        end
    end

    // Line buffers are never cleared; read-before-write moves row-1 into the row-2 buffer.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb0_rd_q   <= lb0[addr];
            lb1_rd_q   <= lb1[addr];
            lb1[addr]  <= lb0[addr];
            lb0[addr]  <= pixel_in;
        end
    end

    assign pixel_out1 = valid_q ? win_q[0] : 8'h00;
    assign pixel_out2 = valid_q ? win_q[1] : 8'h00;
    assign pixel_out3 = valid_q ? win_q[2] : 8'h00;
    assign pixel_out4 = valid_q ? win_q[3] : 8'h00;
    assign pixel_out5 = valid_q ? win_q[4] : 8'h00;
    assign pixel_out6 = valid_q ? win_q[5] : 8'h00;
    assign pixel_out7 = valid_q ? win_q[6] : 8'h00;
    assign pixel_out8 = valid_q ? win_q[7] : 8'h00;
    assign pixel_out9 = valid_q ? win_q[8] : 8'h00;
    assign hsync_out  = hs_dly_q[1];
    assign vsync_out  = vs_dly_q[1];
    assign de_out     = de_dly_q[1];
    assign win_valid  = valid_q;
    assign frame_err  = err_q;

endmodule
